// File: rtl/sio_tx_8x.sv
`default_nettype none
// ============================================================================
// Module      : sio_tx_8x
// Description : 8x-oversampled async-style frame transmitter, 8 samples/clock
//               for an 8:1 serializer; o[7] is the earliest sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sio_tx_8x #(
    parameter int NBITS       = 8,
    parameter int STOP_BITS   = 1,
    parameter int BIT_SAMPLES = 12,
    parameter int INV_ODD     = 0
) (
    input  logic             c,
    input  logic             r,
    input  logic             valid,
    input  logic [NBITS-1:0] d,
    output logic             ready,
    output logic             busy,
    output logic [7:0]       o
);

    localparam int              c_FB        = NBITS + 1 + STOP_BITS;
    localparam int              c_IW        = $clog2(c_FB + 1);
    localparam int              c_PW        = 1 << c_IW;
    localparam logic [c_IW-1:0] c_LAST_BIT  = c_IW'(c_FB - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE   = c_IW'(1);
    localparam logic [7:0]      c_LAST_SAMP = 8'(BIT_SAMPLES - 1);
    localparam logic [7:0]      c_INV_MASK  = (INV_ODD != 0) ? 8'hAA : 8'h00;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [c_FB-1:0]  r_fr;
    logic [c_IW-1:0]  r_bit_idx;
    logic [7:0]       r_samp_cnt;
    logic             r_busy;
    logic [7:0]       r_o;

    logic [c_FB-1:0]  w_new_fr;
    logic             w_idle_accept;
    logic             w_send_accept;
    logic             w_act0;
    logic             w_act;
    logic             w_done;
    logic             w_bit;
    logic [c_PW-1:0]  w_fr_pad;
    logic [c_IW-1:0]  w_idx;
    logic [7:0]       w_cnt;
    logic [7:0]       w_word;

    assign w_new_fr = {{STOP_BITS{1'b1}}, d, 1'b0};

    // An accept from idle feeds the new frame straight into this cycle's word,
    // so the start bit lands on o[7] one cycle after the accept.
    assign w_idle_accept = !r && valid && (r_state == c_IDLE);

    always_comb begin
        w_act0   = (r_state == c_SEND) || w_idle_accept;
        w_fr_pad = {c_PW{1'b1}};
        if (w_idle_accept) begin
            w_fr_pad[c_FB-1:0] = w_new_fr;
            w_idx              = '0;
            w_cnt              = '0;
        end else begin
            w_fr_pad[c_FB-1:0] = r_fr;
            w_idx              = r_bit_idx;
            w_cnt              = r_samp_cnt;
        end
        w_act  = w_act0;
        w_done = 1'b0;
        w_bit  = 1'b1;
        w_word = 8'hFF;
        // Slot 7 first: each pass shifts one sample in at the LSB end.
        for (int s = 0; s < 8; s++) begin
            w_bit = 1'b1;
            if (w_act) begin
                w_bit = w_fr_pad[w_idx];
                if (w_cnt == c_LAST_SAMP) begin
                    w_cnt = '0;
                    if (w_idx == c_LAST_BIT) begin
                        w_act  = 1'b0;
                        w_done = 1'b1;
                    end else begin
                        w_idx = w_idx + c_IDX_ONE;
                    end
                end else begin
                    w_cnt = w_cnt + 8'd1;
                end
            end
            w_word = {w_word[6:0], w_bit};
        end
    end

    assign ready         = !r && ((r_state == c_IDLE) || w_done);
    assign w_send_accept = valid && ready && (r_state == c_SEND);

    always_ff @(posedge c) begin
        if (r) begin
            r_state    <= c_IDLE;
            r_fr       <= '0;
            r_bit_idx  <= '0;
            r_samp_cnt <= '0;
            r_busy     <= 1'b0;
            r_o        <= 8'hFF ^ c_INV_MASK;
        end else begin
            r_o    <= w_word ^ c_INV_MASK;
            r_busy <= w_act0;
            if (w_send_accept) begin
                r_state    <= c_SEND;
                r_fr       <= w_new_fr;
                r_bit_idx  <= '0;
                r_samp_cnt <= '0;
            end else if (w_act) begin
                r_state    <= c_SEND;
                r_fr       <= w_fr_pad[c_FB-1:0];
                r_bit_idx  <= w_idx;
                r_samp_cnt <= w_cnt;
            end else begin
                r_state    <= c_IDLE;
                r_bit_idx  <= '0;
                r_samp_cnt <= '0;
            end
        end
    end

    assign busy = r_busy;
    assign o    = r_o;

endmodule
`default_nettype wire
